// File: rtl/lpf_pkg.sv
// Shared types and constants for the LPF relay sequencer.
// The default tables describe the standard seven-band Alex LPF board.
package lpf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUTE  = 2'd1,
        BREAK = 2'd2,
        MAKE  = 2'd3
    } lpf_state_e;

    localparam int DEF_NUM_BANDS = 7;

    // Upper frequency limit (Hz) of each band; the top band has no upper limit.
    localparam logic [31:0] EDGE [0:DEF_NUM_BANDS-2] = '{
        32'd2000000, 32'd4000000, 32'd7300000,
        32'd14350000, 32'd21450000, 32'd29700000
    };

    // Relay drive pattern for each band, lowest band first.
    localparam logic [DEF_NUM_BANDS-1:0] LPF_CODE [0:DEF_NUM_BANDS-1] = '{
        7'b0001000, 7'b0000100, 7'b0000010, 7'b0000001,
        7'b1000000, 7'b0100000, 7'b0010000
    };

    // Width of an index able to address n items (never narrower than one bit).
    function automatic int band_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lpf_band_hyst.sv
// Band decision path: registered raw decode, hysteresis around the current
// band, and the stability filter that raises o_req once a new target has
// persisted long enough. With LPF_MANUAL_OVERRIDE_EN defined, a manual band
// selection bypasses hysteresis and the stability filter.
module lpf_band_hyst
    import lpf_pkg::*;
#(
    parameter int FREQ_W        = 32,
    parameter int NUM_BANDS     = 7,
    parameter int BAND_W        = 3,
    parameter int HYST_HZ       = 50000,
    parameter int STABLE_CYCLES = 1024
)(
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [FREQ_W-1:0] i_freq,
    input  logic              i_idle,
    input  logic [BAND_W-1:0] i_band,
`ifdef LPF_MANUAL_OVERRIDE_EN
    input  logic              i_manual_en,
    input  logic [BAND_W-1:0] i_manual_band,
`endif
    output logic [BAND_W-1:0] o_pending,
    output logic              o_req
);

    // Limits are compared one bit wider than the frequency so EDGE+HYST cannot wrap.
    localparam int CW       = FREQ_W + 1;
    localparam int STABLE_N = (STABLE_CYCLES < 1) ? 1 : STABLE_CYCLES;
    localparam int CNT_W    = band_width(STABLE_N);

    logic [FREQ_W-1:0] r_freq;
    logic [BAND_W-1:0] r_raw;
    logic [BAND_W-1:0] r_prev_target;
    logic [CNT_W-1:0]  r_cnt;

    logic [BAND_W-1:0] w_raw_next;
    logic [CW-1:0]     w_up_lim;
    logic [CW-1:0]     w_dn_lim;
    logic              w_up_pass;
    logic              w_dn_pass;
    logic [BAND_W-1:0] w_hyst_target;
    logic [BAND_W-1:0] w_target;
    logic              w_manual;
    logic              w_differs;
    logic [CNT_W:0]    w_cnt_now;
    logic [CNT_W:0]    w_cnt_next;

    // Raw decode: lowest band whose edge is at or above the frequency.
    always_comb begin
        w_raw_next = BAND_W'(NUM_BANDS - 1);
        for (int i = NUM_BANDS - 2; i >= 0; i--) begin
            if ({1'b0, i_freq} <= CW'(EDGE[i])) w_raw_next = BAND_W'(i);
        end
    end

    // Hysteresis limits around the current band; the lower one saturates at zero.
    always_comb begin
        w_up_lim = '0;
        w_dn_lim = '0;
        for (int i = 0; i < NUM_BANDS - 1; i++) begin
            if (i_band == BAND_W'(i))
                w_up_lim = CW'(EDGE[i]) + CW'(HYST_HZ);
            if (i_band == BAND_W'(i + 1))
                w_dn_lim = (CW'(EDGE[i]) > CW'(HYST_HZ)) ? (CW'(EDGE[i]) - CW'(HYST_HZ)) : '0;
        end
    end

    assign w_up_pass     = (i_band < BAND_W'(NUM_BANDS - 1)) && ({1'b0, r_freq} > w_up_lim);
    assign w_dn_pass     = (i_band != '0) && ({1'b0, r_freq} <= w_dn_lim);
    assign w_hyst_target = (w_up_pass || w_dn_pass) ? r_raw : i_band;

`ifdef LPF_MANUAL_OVERRIDE_EN
    logic w_manual_ok;
    assign w_manual_ok = {1'b0, i_manual_band} < (BAND_W + 1)'(NUM_BANDS);
    assign w_manual    = i_manual_en;
    assign w_target    = i_manual_en ? (w_manual_ok ? i_manual_band : i_band) : w_hyst_target;
`else
    assign w_manual    = 1'b0;
    assign w_target    = w_hyst_target;
`endif

    // Stability count: length of the current run of one unchanged, differing target.
    always_comb begin
        w_differs  = (w_target != i_band);
        w_cnt_now  = (w_target == r_prev_target) ? ({1'b0, r_cnt} + (CNT_W + 1)'(1)) : '0;
        w_cnt_next = (i_idle && w_differs) ? w_cnt_now : '0;
        o_req      = i_idle && w_differs &&
                     (w_manual || (w_cnt_now == (CNT_W + 1)'(STABLE_N - 1)));
        o_pending  = w_target;
    end

    // Capture frequency/raw band and track the previous target; outside IDLE the
    // previous target is pinned to the driven band so a new run starts fresh.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_freq        <= '0;
            r_raw         <= '0;
            r_prev_target <= '0;
            r_cnt         <= '0;
        end else begin
            r_freq        <= i_freq;
            r_raw         <= w_raw_next;
            r_prev_target <= i_idle ? w_target : i_band;
            r_cnt         <= w_cnt_next[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/lpf_relay_sequencer.sv
// LPF relay sequencer: selects a low-pass filter from the tuned frequency and
// switches relays break-before-make (MUTE -> BREAK -> MAKE) with TX inhibited.
// Optional manual band selection is compiled in with LPF_MANUAL_OVERRIDE_EN.
// Handshake: none; o_req from the band path is a level that is only acted on
// in IDLE, and the pending band is latched on that same cycle.
module lpf_relay_sequencer
    import lpf_pkg::*;
#(
    parameter int FREQ_W        = 32,
    parameter int NUM_BANDS     = 7,
    parameter int HYST_HZ       = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MUTE_CYCLES   = 256,
    parameter int BREAK_CYCLES  = 512,
    parameter int SETTLE_CYCLES = 2048
)(
    input  logic                                clock,
    input  logic                                reset,
    input  logic [FREQ_W-1:0]                   frequency,
`ifdef LPF_MANUAL_OVERRIDE_EN
    input  logic                                manual_en,
    input  logic [band_width(NUM_BANDS)-1:0]    manual_band,
`endif
    output logic [NUM_BANDS-1:0]                LPF,
    output logic [band_width(NUM_BANDS)-1:0]    band,
    output logic                                tx_inhibit,
    output logic                                busy
);

    localparam int BAND_W   = band_width(NUM_BANDS);
    localparam int MUTE_N   = (MUTE_CYCLES   < 1) ? 1 : MUTE_CYCLES;
    localparam int BREAK_N  = (BREAK_CYCLES  < 1) ? 1 : BREAK_CYCLES;
    localparam int SETTLE_N = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int MAX_A    = (MUTE_N > BREAK_N) ? MUTE_N : BREAK_N;
    localparam int MAX_N    = (MAX_A > SETTLE_N) ? MAX_A : SETTLE_N;
    localparam int TMR_W    = band_width(MAX_N);

    lpf_state_e           r_state;
    logic [TMR_W-1:0]     r_tmr;
    logic [NUM_BANDS-1:0] r_lpf;
    logic [BAND_W-1:0]    r_band;
    logic [BAND_W-1:0]    r_pending;

    lpf_state_e           w_state_next;
    logic [TMR_W-1:0]     w_tmr_next;
    logic [NUM_BANDS-1:0] w_lpf_next;
    logic [BAND_W-1:0]    w_band_next;
    logic [BAND_W-1:0]    w_pending_next;
    logic [NUM_BANDS-1:0] w_code;
    logic [BAND_W-1:0]    w_hyst_pending;
    logic                 w_req;

    lpf_band_hyst #(
        .FREQ_W        (FREQ_W),
        .NUM_BANDS     (NUM_BANDS),
        .BAND_W        (BAND_W),
        .HYST_HZ       (HYST_HZ),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_band_hyst (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_freq        (frequency),
        .i_idle        (r_state == IDLE),
        .i_band        (r_band),
`ifdef LPF_MANUAL_OVERRIDE_EN
        .i_manual_en   (manual_en),
        .i_manual_band (manual_band),
`endif
        .o_pending     (w_hyst_pending),
        .o_req         (w_req)
    );

    // Relay pattern for the latched pending band.
    always_comb begin
        w_code = '0;
        for (int i = 0; i < NUM_BANDS; i++) begin
            if (r_pending == BAND_W'(i)) w_code = NUM_BANDS'(LPF_CODE[i]);
        end
    end

    // Next-state: each sequence state lasts exactly its (minimum one) cycle count;
    // relays open entering BREAK and the new band is driven entering MAKE.
    always_comb begin
        w_state_next   = r_state;
        w_tmr_next     = r_tmr + TMR_W'(1);
        w_lpf_next     = r_lpf;
        w_band_next    = r_band;
        w_pending_next = r_pending;
        case (r_state)
            IDLE: begin
                w_tmr_next = '0;
                if (w_req) begin
                    w_pending_next = w_hyst_pending;
                    w_state_next   = MUTE;
                end
            end
            MUTE: begin
                if (r_tmr == TMR_W'(MUTE_N - 1)) begin
                    w_tmr_next   = '0;
                    w_lpf_next   = '0;
                    w_state_next = BREAK;
                end
            end
            BREAK: begin
                if (r_tmr == TMR_W'(BREAK_N - 1)) begin
                    w_tmr_next   = '0;
                    w_lpf_next   = w_code;
                    w_band_next  = r_pending;
                    w_state_next = MAKE;
                end
            end
            MAKE: begin
                if (r_tmr == TMR_W'(SETTLE_N - 1)) begin
                    w_tmr_next   = '0;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_tmr_next   = '0;
                w_state_next = IDLE;
            end
        endcase
    end

    // State, timer and relay registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_tmr     <= '0;
            r_lpf     <= NUM_BANDS'(LPF_CODE[0]);
            r_band    <= '0;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_next;
            r_tmr     <= w_tmr_next;
            r_lpf     <= w_lpf_next;
            r_band    <= w_band_next;
            r_pending <= w_pending_next;
        end
    end

    assign LPF        = r_lpf;
    assign band       = r_band;
    assign tx_inhibit = (r_state != IDLE);
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_lpf_relay_sequencer.sv
// Testbench for lpf_relay_sequencer: directed scenarios plus randomized
// frequency hops, checked cycle by cycle against a behavioural model.
module tb_lpf_relay_sequencer;

  localparam int NB     = 7;
  localparam int BW     = 3;
  localparam int HYST   = 50000;
  localparam int STABLE = 4;
  localparam int MUTE   = 2;
  localparam int BRK    = 3;
  localparam int SETTLE = 5;
  localparam int OW     = NB + BW + 2;

  localparam longint EDGE_HZ [0:5] = '{2000000, 4000000, 7300000, 14350000, 21450000, 29700000};
  localparam logic [NB-1:0] CODE_TAB [0:NB-1] = '{7'b0001000, 7'b0000100, 7'b0000010,
                                                   7'b0000001, 7'b1000000, 7'b0100000, 7'b0010000};

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   frequency = '0;
  logic [NB-1:0] LPF;
  logic [BW-1:0] band;
  logic          tx_inhibit;
  logic          busy;
`ifdef LPF_MANUAL_OVERRIDE_EN
  logic          manual_en = 1'b0;
  logic [BW-1:0] manual_band = '0;
`endif

  always #5 clock = ~clock;

  lpf_relay_sequencer #(
    .FREQ_W(32), .NUM_BANDS(NB), .HYST_HZ(HYST), .STABLE_CYCLES(STABLE),
    .MUTE_CYCLES(MUTE), .BREAK_CYCLES(BRK), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .frequency(frequency),
`ifdef LPF_MANUAL_OVERRIDE_EN
    .manual_en(manual_en),
    .manual_band(manual_band),
`endif
    .LPF(LPF),
    .band(band),
    .tx_inhibit(tx_inhibit),
    .busy(busy)
  );

  // ---------------- reference model ----------------
  logic [OW-1:0]    exp_q[$];
  logic [NB+BW-1:0] dir_q[$];
  int n_vec = 0;
  int n_err = 0;

  bit     m_in_seq;
  int     m_el, m_band, m_pending, m_run, m_run_t;
  longint m_freq;

  function automatic int raw_of(input longint f);
    for (int i = 0; i < NB - 1; i++) if (f <= EDGE_HZ[i]) return i;
    return NB - 1;
  endfunction

  function automatic int target_of(input longint f, input int b);
    longint lo;
    if (b < NB - 1 && f > EDGE_HZ[b] + HYST) return raw_of(f);
    if (b > 0) begin
      lo = EDGE_HZ[b-1] - HYST;
      if (lo < 0) lo = 0;
      if (f <= lo) return raw_of(f);
    end
    return b;
  endfunction

  // Advance the model by one clock edge at which frequency f and reset rst are sampled.
  task automatic model_edge(input longint f, input bit rst);
    int t;
    logic [NB-1:0] e_lpf;
    logic [BW-1:0] e_band;
    logic e_tx;
    if (rst) begin
      m_in_seq = 0; m_el = 0; m_band = 0; m_pending = 0;
      m_run = 0; m_run_t = 0; m_freq = 0;
    end else begin
      if (m_in_seq) begin
        m_el++;
        if (m_el == MUTE + BRK) m_band = m_pending;
        if (m_el == MUTE + BRK + SETTLE) m_in_seq = 0;
        m_run = 0;
      end else begin
        t = target_of(m_freq, m_band);
        if (t == m_band) m_run = 0;
        else if (m_run > 0 && t == m_run_t) m_run++;
        else begin m_run = 1; m_run_t = t; end
        if (m_run == STABLE) begin
          m_in_seq = 1; m_el = 0; m_pending = t; m_run = 0;
        end
      end
      m_freq = f;
    end
    e_band = BW'(m_band);
    e_tx   = m_in_seq;
    if (m_in_seq && m_el >= MUTE && m_el < MUTE + BRK) e_lpf = '0;
    else e_lpf = CODE_TAB[m_band];
    exp_q.push_back({e_lpf, e_band, e_tx, e_tx});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [31:0] f, input bit rst);
    @(negedge clock);
    frequency = f;
    reset = rst;
    @(posedge clock);
    #1;
    model_edge(longint'(f), rst);
  endtask

  task automatic hold(input logic [31:0] f, input int n);
    repeat (n) cycle(f, 1'b0);
  endtask

  // Fixed expectation for the outputs of the cycle just issued.
  task automatic expect_now(input logic [NB-1:0] l, input logic [BW-1:0] b);
    dir_q.push_back({l, b});
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [OW-1:0]    exp_v, act_v;
  logic [NB+BW-1:0] dir_v;

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {LPF, band, tx_inhibit, busy};
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL outputs t=%0t got LPF=%b band=%0d tx=%b busy=%b want LPF=%b band=%0d tx=%b busy=%b",
                 $time, LPF, band, tx_inhibit, busy,
                 exp_v[OW-1 -: NB], exp_v[BW+1 -: BW], exp_v[1], exp_v[0]);
      end
      n_vec++;
      if ($countones(LPF) > 1 || $isunknown(LPF)) begin
        n_err++;
        $display("FAIL lpf_onehot t=%0t got LPF=%b want at most one bit set", $time, LPF);
      end
    end
    if (dir_q.size() > 0) begin
      dir_v = dir_q.pop_front();
      n_vec++;
      if ({LPF, band} !== dir_v) begin
        n_err++;
        $display("FAIL directed t=%0t got LPF=%b band=%0d want LPF=%b band=%0d",
                 $time, LPF, band, dir_v[NB+BW-1 -: NB], dir_v[BW-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  int          e_idx;
  longint      off;
  logic [31:0] f_r;

  initial begin
    // Reset with 7.1 MHz present, then the 0 -> 2 switch.
    repeat (3) cycle(32'd7100000, 1'b1);
    expect_now(7'b0001000, 3'd0);
    hold(32'd7100000, 20);
    expect_now(7'b0000010, 3'd2);

    // Hysteresis around the 7.3 MHz edge.
    hold(32'd7320000, 20);
    expect_now(7'b0000010, 3'd2);
    hold(32'd7360000, 20);
    expect_now(7'b0000001, 3'd3);
    hold(32'd7260000, 20);
    expect_now(7'b0000001, 3'd3);

    // Chatter across the 4 MHz edge while in band 1: never stable long enough.
    hold(32'd3000000, 20);
    expect_now(7'b0000100, 3'd1);
    for (int i = 0; i < 34; i++) hold((i % 2 == 0) ? 32'd4100000 : 32'd3900000, 3);
    expect_now(7'b0000100, 3'd1);

    // Multi-band jump in one sequence.
    hold(32'd1800000, 20);
    expect_now(7'b0001000, 3'd0);
    hold(32'd50000000, 20);
    expect_now(7'b0010000, 3'd6);

    // Frequency moves during BREAK of a 1 -> 2 switch.
    hold(32'd3000000, 20);
    hold(32'd7100000, 8);
    hold(32'd14000000, 30);
    expect_now(7'b0000001, 3'd3);

    // Reset during MAKE of a 3 -> 2 switch.
    hold(32'd7100000, 11);
    cycle(32'd7100000, 1'b1);
    expect_now(7'b0001000, 3'd0);
    hold(32'd7100000, 20);
    expect_now(7'b0000010, 3'd2);

    // Randomized hops, mostly near band edges, with occasional reset.
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        f_r = 32'($urandom_range(0, 60000000));
      end else begin
        e_idx = $urandom_range(0, 5);
        off   = longint'($urandom_range(0, 240000)) - 120000;
        f_r   = 32'(EDGE_HZ[e_idx] + off);
      end
      if ($urandom_range(0, 60) == 0) cycle(f_r, 1'b1);
      else hold(f_r, $urandom_range(1, 12));
    end
    hold(f_r, 25);

    repeat (3) @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
